// File: rtl/lp_fltr_pkg.sv
// Shared constants and the EMA update rule for the multi-channel low-pass filter.
// The update uses plain int arithmetic, so any accumulator width up to 30 bits fits.
package lp_fltr_pkg;

  localparam int FRAC_DEF = 4;
  localparam int K_W      = 3;

  // Returns the next accumulator value, clamped to [0, acc_max].
  // The shift on a signed int is arithmetic, which gives floor division by 2^k.
  function automatic int ema_upd(input int acc, input int x, input logic [K_W-1:0] k,
                                 input logic prime, input int acc_max);
    int d;
    int r;
    if (prime) begin
      r = x;
    end else begin
      d = x - acc;
      r = acc + (d >>> k);
    end
    if (r < 0) begin
      r = 0;
    end else if (r > acc_max) begin
      r = acc_max;
    end
    return r;
  endfunction

endpackage

// File: rtl/lp_fltr_mc_if.sv
// Sample-in / sample-out bundle of the multi-channel filter.
// The source side uses master and the filter uses slave.
interface lp_fltr_mc_if
  import lp_fltr_pkg::*;
#(
  parameter int DW = 8,
  parameter int CH = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           in_valid;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  din;
  logic [K_W-1:0] k;
  logic           bypass;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  dout;

  modport master (output in_valid, in_ch, din, k, bypass,
                  input  out_valid, out_ch, dout);
  modport slave  (input  in_valid, in_ch, din, k, bypass,
                  output out_valid, out_ch, dout);
endinterface

// File: rtl/lp_fltr_state.sv
// Per-channel {primed, acc} registers with one combinational read port, one write port,
// a global clear, and bypass of the value being written this cycle onto the read port.
module lp_fltr_state #(
  parameter int CH  = 4,
  parameter int AW  = 12,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           clr,
  input  logic [CHW-1:0] rd_ch,
  output logic [AW-1:0]  rd_acc,
  output logic           rd_primed,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [AW-1:0]  wr_acc
);

  logic [AW:0] st_q [CH];

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [AW:0] st_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          st_reg <= '0;
        end else if (ce) begin
          if (clr) begin
            st_reg <= '0;
          end else if (wr_en && (wr_ch == CHW'(gi))) begin
            st_reg <= {1'b1, wr_acc};
          end
        end
      end

      assign st_q[gi] = st_reg;
    end
  endgenerate

  // A sample being written back this cycle is newer than the stored copy.
  always_comb begin
    rd_acc    = '0;
    rd_primed = 1'b0;
    if (wr_en && (wr_ch == rd_ch)) begin
      rd_acc    = wr_acc;
      rd_primed = 1'b1;
    end else if (int'(rd_ch) < CH) begin
      rd_acc    = st_q[rd_ch][AW-1:0];
      rd_primed = st_q[rd_ch][AW];
    end
  end

endmodule

// File: rtl/lp_fltr_mc.sv
// Time-multiplexed first-order IIR low-pass (EMA) shared across CH interleaved channels.
// Two-stage pipeline: S1 captures the sample and its channel state, S2 updates and outputs.
module lp_fltr_mc
  import lp_fltr_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CH   = 4,
  parameter int FRAC = FRAC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        clr,
  lp_fltr_mc_if.slave bus
);

  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW   = DW + FRAC;
  localparam int AMAX = (1 << AW) - 1;

  logic           s1_valid_reg;
  logic [CHW-1:0] s1_ch_reg;
  logic [DW-1:0]  s1_din_reg;
  logic [K_W-1:0] s1_k_reg;
  logic           s1_bypass_reg;
  logic [AW-1:0]  s1_acc_reg;
  logic           s1_primed_reg;

  logic           out_valid_reg;
  logic [CHW-1:0] out_ch_reg;
  logic [DW-1:0]  dout_reg;

  logic           in_ok;
  logic [AW-1:0]  rd_acc;
  logic           rd_primed;
  logic [AW-1:0]  acc_next;
  logic           prime;

  assign in_ok = bus.in_valid && (int'(bus.in_ch) < CH);
  assign prime = !s1_primed_reg || s1_bypass_reg;

  always_comb begin
    acc_next = AW'(ema_upd(int'(s1_acc_reg), int'({s1_din_reg, {FRAC{1'b0}}}),
                           s1_k_reg, prime, AMAX));
  end

  lp_fltr_state #(
    .CH  (CH),
    .AW  (AW),
    .CHW (CHW)
  ) u_state (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .clr       (clr),
    .rd_ch     (bus.in_ch),
    .rd_acc    (rd_acc),
    .rd_primed (rd_primed),
    .wr_en     (s1_valid_reg),
    .wr_ch     (s1_ch_reg),
    .wr_acc    (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_ch_reg     <= '0;
      s1_din_reg    <= '0;
      s1_k_reg      <= '0;
      s1_bypass_reg <= 1'b0;
      s1_acc_reg    <= '0;
      s1_primed_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      dout_reg      <= '0;
    end else if (ce) begin
      if (clr) begin
        // Kill both stages; the incoming sample is discarded.
        s1_valid_reg  <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        s1_valid_reg  <= in_ok;
        s1_ch_reg     <= bus.in_ch;
        s1_din_reg    <= bus.din;
        s1_k_reg      <= bus.k;
        s1_bypass_reg <= bus.bypass;
        s1_acc_reg    <= rd_acc;
        s1_primed_reg <= rd_primed;
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_ch_reg <= s1_ch_reg;
          dout_reg   <= acc_next[AW-1:FRAC];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.dout      = dout_reg;

endmodule

// File: tb/tb_lp_fltr_mc.sv
// Self-checking bench for lp_fltr_mc: directed scenarios plus randomized traffic
// checked against an integer per-channel EMA model.
module tb_lp_fltr_mc;
  import lp_fltr_pkg::*;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int FR = 4;

  logic clk = 1'b0;
  logic rst, ce, clr;
  logic rst3, ce3, clr3;

  always #5 clk = ~clk;

  lp_fltr_mc_if #(.DW(DW), .CH(CH)) bus ();
  lp_fltr_mc_if #(.DW(DW), .CH(3))  bus3 ();

  lp_fltr_mc #(.DW(DW), .CH(CH), .FRAC(FR)) dut (
    .clk (clk), .rst (rst), .ce (ce), .clr (clr), .bus (bus)
  );

  lp_fltr_mc #(.DW(DW), .CH(3), .FRAC(FR)) dut3 (
    .clk (clk), .rst (rst3), .ce (ce3), .clr (clr3), .bus (bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: channel state plus the result waiting to appear on the outputs.
  int m_acc [CH];
  bit m_pr  [CH];
  bit p_v;
  int p_ch, p_d;
  bit e_ov;
  int e_ch, e_d;

  function automatic int fdiv(input int d, input int kk);
    int p;
    p = 2 ** kk;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  task automatic model_step(input bit r, input bit c, input bit v, input int ch, input int dn,
                            input int kk, input bit by, input bit cl);
    int x, a;
    if (r) begin
      for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_pr[i] = 0; end
      p_v = 0; e_ov = 0; e_ch = 0; e_d = 0;
    end else if (c) begin
      if (cl) begin
        for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_pr[i] = 0; end
        p_v = 0; e_ov = 0;
      end else begin
        e_ov = p_v;
        if (p_v) begin e_ch = p_ch; e_d = p_d; end
        p_v = v && (ch < CH);
        if (p_v) begin
          x = dn * (2 ** FR);
          if (!m_pr[ch] || by) a = x;
          else a = m_acc[ch] + fdiv(x - m_acc[ch], kk);
          if (a < 0) a = 0;
          if (a > (2 ** (DW + FR)) - 1) a = (2 ** (DW + FR)) - 1;
          m_acc[ch] = a;
          m_pr[ch]  = 1;
          p_ch = ch;
          p_d  = a / (2 ** FR);
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input int ch, input int dn,
                     input int kk, input bit by, input bit cl);
    rst = r; ce = c; clr = cl;
    bus.in_valid = v; bus.in_ch = ch[1:0]; bus.din = dn[7:0]; bus.k = kk[2:0]; bus.bypass = by;
    @(posedge clk);
    model_step(r, c, v, ch, dn, kk, by, cl);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    if (e_ov) begin
      chk("out_ch", 32'(bus.out_ch), e_ch);
      chk("dout", 32'(bus.dout), e_d);
    end
    if (bus.out_valid && ce)
      $display("t=%0t ch=%0d dout=%0d (model ch=%0d dout=%0d)", $time, bus.out_ch, bus.dout, e_ch, e_d);
  endtask

  task automatic send(input int ch, input int dn, input int kk, input bit by);
    cyc(0, 1, 1, ch, dn, kk, by, 0);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst3 = 1; ce3 = 1; clr3 = 0;
    bus3.in_valid = 0; bus3.in_ch = '0; bus3.din = '0; bus3.k = '0; bus3.bypass = 0;

    // Reset state
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 2, 9, 1, 0, 1);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_ch", 32'(bus.out_ch), 0);
    chk("rst_dout", 32'(bus.dout), 0);

    // 1: prime then decay with k=1
    send(0, 200, 1, 0);
    send(0, 0, 1, 0);   chk("t1_prime", 32'(bus.dout), 200);
    send(0, 0, 1, 0);   chk("t1_d100", 32'(bus.dout), 100);
    send(0, 0, 1, 0);   chk("t1_d50", 32'(bus.dout), 50);
    idle();             chk("t1_d25", 32'(bus.dout), 25);

    // 2: back-to-back on one channel exercises forwarding
    send(1, 0, 1, 0);
    send(1, 255, 1, 0);
    send(1, 255, 1, 0); chk("t2_d127", 32'(bus.dout), 127);
    idle();             chk("t2_d191", 32'(bus.dout), 191);
    chk("t2_ch", 32'(bus.out_ch), 1);

    // 3: k=0 pass-through; bypass then resume filtering from the bypassed value
    send(2, 17, 0, 0);
    send(2, 230, 0, 0); chk("t3_k0a", 32'(bus.dout), 17);
    idle();             chk("t3_k0b", 32'(bus.dout), 230);
    send(3, 0, 3, 0);
    send(3, 99, 3, 1);
    send(3, 0, 3, 0);   chk("t3_byp", 32'(bus.dout), 99);
    idle();             chk("t3_after", 32'(bus.dout), 86);

    // 4: interleaved channels with a 3-cycle ce stall
    for (int i = 0; i < 12; i++) begin
      if (i == 6)
        for (int j = 0; j < 3; j++) cyc(0, 0, 1, j, $urandom_range(0, 255), 1, 0, 0);
      send(i % 4, $urandom_range(0, 255), $urandom_range(0, 7), 0);
    end
    idle(); idle();

    // 5: clear with samples in flight
    send(0, 10, 2, 0);
    send(1, 20, 2, 0);
    cyc(0, 1, 1, 2, 33, 2, 0, 1); chk("t5_kill0", 32'(bus.out_valid), 0);
    idle();                       chk("t5_kill1", 32'(bus.out_valid), 0);
    send(0, 50, 2, 0);
    idle();                       chk("t5_prime", 32'(bus.dout), 50);
    chk("t5_ov", 32'(bus.out_valid), 1);

    // 5b: out-of-range channel on a 3-channel instance
    ce = 0; bus.in_valid = 0;
    @(posedge clk); #1;
    rst3 = 0;
    chk("ch3_rst_ov", 32'(bus3.out_valid), 0);
    bus3.in_valid = 1; bus3.in_ch = 2'd3; bus3.din = 8'd44; bus3.k = 3'd1;
    @(posedge clk); #1;
    bus3.in_valid = 0;
    @(posedge clk); #1; chk("ch3_drop0", 32'(bus3.out_valid), 0);
    @(posedge clk); #1; chk("ch3_drop1", 32'(bus3.out_valid), 0);
    bus3.in_valid = 1; bus3.in_ch = 2'd2; bus3.din = 8'd77; bus3.k = 3'd2;
    @(posedge clk); #1;
    bus3.in_valid = 0;
    @(posedge clk); #1;
    chk("ch3_ok_ov", 32'(bus3.out_valid), 1);
    chk("ch3_ok_ch", 32'(bus3.out_ch), 2);
    chk("ch3_ok_dout", 32'(bus3.dout), 77);

    // 6: reset mid-stream while ce=0
    send(1, 120, 2, 0);
    send(2, 130, 2, 0);
    cyc(1, 0, 1, 3, 5, 1, 0, 0);
    chk("t6_ov", 32'(bus.out_valid), 0);
    chk("t6_ch", 32'(bus.out_ch), 0);
    chk("t6_dout", 32'(bus.dout), 0);
    send(2, 123, 4, 0);
    idle();            chk("t6_prime", 32'(bus.dout), 123);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, CH - 1), $urandom_range(0, 255), $urandom_range(0, 7),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
